// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Control sequencer for the ProgramCounter register. Walks the fetch loop
//   (boot delay, idle, fetch handshake, branch flush, halt) and drives the PC
//   load enable and PCSrc select. Also counts retired instructions for debug.
//
// Ports
//   clk            in   rising-edge clock
//   Areset         in   asynchronous reset, active-high
//   run            in   core enable; 0 parks the sequencer in IDLE
//   imem_ready     in   instruction memory holds the word at PC this cycle
//   stall          in   hazard stall; current instruction is not accepted
//   branch_taken   in   decoded instruction is a taken branch/jump
//   halt_req       in   decoded instruction is ECALL/EBREAK
//   load           out  PC register load enable (combinational)
//   PCSrc          out  0 = PC+4, 1 = branch target (combinational)
//   instr_valid    out  instruction accepted/retired this cycle (combinational)
//   flush          out  squash the fetched word (decoded from state)
//   halted         out  core halted (decoded from state)
//   state          out  BOOT=0, IDLE=1, FETCH=2, FLUSH=3, HALT=4
//   retired_count  out  instructions retired since reset, wraps silently

module pc_fetch_sequencer #(
  parameter int unsigned BOOT_DELAY   = 2,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        Areset,
  input  logic        run,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        halt_req,
  output logic        load,
  output logic        PCSrc,
  output logic        instr_valid,
  output logic        flush,
  output logic        halted,
  output logic [2:0]  state,
  output logic [31:0] retired_count
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned BOOT_W  = 4;
  localparam int unsigned FLUSH_W = 3;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    S_BOOT  = 3'd0,
    S_IDLE  = 3'd1,
    S_FETCH = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [BOOT_W-1:0]  boot_cnt_q, boot_cnt_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   retired_count_q, retired_count_d;
  logic               accept;

  // State and counter registers; reset aborts any sequence immediately.
  always_ff @(posedge clk or posedge Areset) begin
    if (Areset) begin
      state_q         <= S_BOOT;
      boot_cnt_q      <= BOOT_W'(BOOT_DELAY);
      flush_cnt_q     <= FLUSH_W'(FLUSH_CYCLES);
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      boot_cnt_q      <= boot_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Next-state and PC control decode.
  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    flush_cnt_d = flush_cnt_q;
    load        = 1'b0;
    PCSrc       = 1'b0;
    instr_valid = 1'b0;
    accept      = run & imem_ready & ~stall;

    case (state_q)
      S_BOOT: begin
        // A delay of 0 or 1 both leave on the first edge after release.
        if (boot_cnt_q <= BOOT_W'(1)) begin
          state_d = S_IDLE;
        end else begin
          boot_cnt_d = boot_cnt_q - BOOT_W'(1);
        end
      end

      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (accept) begin
          instr_valid = 1'b1;
          if (halt_req) begin
            // PC stays on the ECALL/EBREAK word.
            state_d = S_HALT;
          end else begin
            load = 1'b1;
            if (branch_taken) begin
              PCSrc       = 1'b1;
              state_d     = S_FLUSH;
              flush_cnt_d = FLUSH_W'(FLUSH_CYCLES);
            end
          end
        end
      end

      S_FLUSH: begin
        // Only run is looked at here, and only on the last bubble cycle.
        if (flush_cnt_q <= FLUSH_W'(1)) begin
          state_d     = run ? S_FETCH : S_IDLE;
          flush_cnt_d = FLUSH_W'(FLUSH_CYCLES);
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // Retired-instruction counter, free-running wrap.
  always_comb begin
    retired_count_d = retired_count_q + CNT_W'(instr_valid);
  end

  assign flush         = (state_q == S_FLUSH);
  assign halted        = (state_q == S_HALT);
  assign state         = STATE_W'(state_q);
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer. Two instances share stimulus:
// dut_a uses FLUSH_CYCLES=1, dut_b uses FLUSH_CYCLES=3. Expected outputs are
// pushed to a scoreboard queue as stimulus is driven and popped when sampled.

module tb_pc_fetch_sequencer;

  typedef struct packed {
    logic [2:0]  st;
    logic        ld;
    logic        src;
    logic        iv;
    logic        fl;
    logic        hl;
    logic [31:0] cnt;
  } obs_t;

  typedef struct packed {
    logic run;
    logic rdy;
    logic stl;
    logic br;
    logic hlt;
  } stim_t;

  logic        clk = 1'b0;
  logic        areset_a, areset_b;
  logic        run, imem_ready, stall, branch_taken, halt_req;

  logic        a_load, a_pcsrc, a_valid, a_flush, a_halted;
  logic [2:0]  a_state;
  logic [31:0] a_count;
  logic        b_load, b_pcsrc, b_valid, b_flush, b_halted;
  logic [2:0]  b_state;
  logic [31:0] b_count;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.BOOT_DELAY(2), .FLUSH_CYCLES(1)) dut_a (
    .clk(clk), .Areset(areset_a), .run(run), .imem_ready(imem_ready),
    .stall(stall), .branch_taken(branch_taken), .halt_req(halt_req),
    .load(a_load), .PCSrc(a_pcsrc), .instr_valid(a_valid), .flush(a_flush),
    .halted(a_halted), .state(a_state), .retired_count(a_count)
  );

  pc_fetch_sequencer #(.BOOT_DELAY(2), .FLUSH_CYCLES(3)) dut_b (
    .clk(clk), .Areset(areset_b), .run(run), .imem_ready(imem_ready),
    .stall(stall), .branch_taken(branch_taken), .halt_req(halt_req),
    .load(b_load), .PCSrc(b_pcsrc), .instr_valid(b_valid), .flush(b_flush),
    .halted(b_halted), .state(b_state), .retired_count(b_count)
  );

  function automatic obs_t mk(input int st, input bit ld, input bit src,
                              input bit iv, input bit fl, input bit hl,
                              input logic [31:0] cnt);
    obs_t o;
    o.st  = 3'(st);
    o.ld  = ld;
    o.src = src;
    o.iv  = iv;
    o.fl  = fl;
    o.hl  = hl;
    o.cnt = cnt;
    return o;
  endfunction

  function automatic stim_t s(input bit r, input bit rdy, input bit stl,
                              input bit br, input bit hlt);
    stim_t x;
    x.run = r;
    x.rdy = rdy;
    x.stl = stl;
    x.br  = br;
    x.hlt = hlt;
    return x;
  endfunction

  function automatic obs_t sample(input bit which);
    obs_t o;
    if (which) begin
      o = {b_state, b_load, b_pcsrc, b_valid, b_flush, b_halted, b_count};
    end else begin
      o = {a_state, a_load, a_pcsrc, a_valid, a_flush, a_halted, a_count};
    end
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d ld=%b src=%b iv=%b fl=%b hl=%b cnt=%h",
                     o.st, o.ld, o.src, o.iv, o.fl, o.hl, o.cnt);
  endfunction

  task automatic drive(input stim_t x);
    run          = x.run;
    imem_ready   = x.rdy;
    stall        = x.stl;
    branch_taken = x.br;
    halt_req     = x.hlt;
  endtask

  // Boot sequence 0,0,1,2 and first load presented before the 4th edge.
  task automatic test_reset();
    stim_t sv[4];
    obs_t  ev[4];
    obs_t  got, want;
    drive(s(1, 1, 0, 0, 0));
    areset_a = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 32'd0));
    #1;
    got  = sample(0);
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_hold: got %s, required %s", fmt(got), fmt(want));
    end
    areset_a = 1'b0;
    sv = '{s(1, 1, 0, 0, 0), s(1, 1, 0, 0, 0), s(1, 1, 0, 0, 0), s(0, 1, 0, 0, 0)};
    ev = '{mk(0, 0, 0, 0, 0, 0, 32'd0), mk(1, 0, 0, 0, 0, 0, 32'd0),
           mk(2, 1, 0, 1, 0, 0, 32'd0), mk(2, 0, 0, 0, 0, 0, 32'd1)};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(sv[i]);
      exp_q.push_back(ev[i]);
      #1;
      got  = sample(0);
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL boot[%0d]: got %s, required %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // Five sequential fetches, then memory not ready.
  task automatic test_fetch();
    stim_t sv[9];
    obs_t  ev[9];
    obs_t  got, want;
    @(negedge clk);
    drive(s(1, 0, 0, 0, 0));
    areset_a = 1'b1;
    @(negedge clk);
    areset_a = 1'b0;
    sv = '{s(1, 0, 0, 0, 0), s(1, 0, 0, 0, 0), s(1, 0, 0, 0, 0),
           s(1, 1, 0, 0, 0), s(1, 1, 0, 0, 0), s(1, 1, 0, 0, 0),
           s(1, 1, 0, 0, 0), s(1, 1, 0, 0, 0), s(1, 0, 0, 0, 0)};
    ev = '{mk(0, 0, 0, 0, 0, 0, 32'd0), mk(1, 0, 0, 0, 0, 0, 32'd0),
           mk(2, 0, 0, 0, 0, 0, 32'd0),
           mk(2, 1, 0, 1, 0, 0, 32'd0), mk(2, 1, 0, 1, 0, 0, 32'd1),
           mk(2, 1, 0, 1, 0, 0, 32'd2), mk(2, 1, 0, 1, 0, 0, 32'd3),
           mk(2, 1, 0, 1, 0, 0, 32'd4), mk(2, 0, 0, 0, 0, 0, 32'd5)};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(sv[i]);
      exp_q.push_back(ev[i]);
      #1;
      got  = sample(0);
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL fetch[%0d]: got %s, required %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // Taken branch -> one bubble -> FETCH; second branch exits flush to IDLE.
  task automatic test_branch();
    stim_t sv[9];
    obs_t  ev[9];
    obs_t  got, want;
    sv = '{s(1, 1, 0, 1, 0), s(1, 1, 0, 1, 1), s(1, 1, 0, 0, 0),
           s(0, 1, 0, 0, 0), s(0, 1, 0, 0, 0), s(1, 0, 0, 0, 0),
           s(1, 1, 0, 1, 0), s(0, 1, 0, 1, 0), s(0, 0, 0, 0, 0)};
    ev = '{mk(2, 1, 1, 1, 0, 0, 32'd5), mk(3, 0, 0, 0, 1, 0, 32'd6),
           mk(2, 1, 0, 1, 0, 0, 32'd6), mk(2, 0, 0, 0, 0, 0, 32'd7),
           mk(1, 0, 0, 0, 0, 0, 32'd7), mk(1, 0, 0, 0, 0, 0, 32'd7),
           mk(2, 1, 1, 1, 0, 0, 32'd7), mk(3, 0, 0, 0, 1, 0, 32'd8),
           mk(1, 0, 0, 0, 0, 0, 32'd8)};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(sv[i]);
      exp_q.push_back(ev[i]);
      #1;
      got  = sample(0);
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %s, required %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // Stall beats halt and branch; releasing stall halts (halt beats branch).
  task automatic test_stall_priority();
    stim_t sv[6];
    obs_t  ev[6];
    obs_t  got, want;
    sv = '{s(1, 1, 0, 0, 0), s(1, 1, 1, 1, 1), s(1, 1, 1, 1, 1),
           s(1, 1, 1, 1, 1), s(1, 1, 0, 1, 1), s(1, 1, 0, 1, 1)};
    ev = '{mk(1, 0, 0, 0, 0, 0, 32'd8), mk(2, 0, 0, 0, 0, 0, 32'd8),
           mk(2, 0, 0, 0, 0, 0, 32'd8), mk(2, 0, 0, 0, 0, 0, 32'd8),
           mk(2, 0, 0, 1, 0, 0, 32'd8), mk(4, 0, 0, 0, 0, 1, 32'd9)};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(sv[i]);
      exp_q.push_back(ev[i]);
      #1;
      got  = sample(0);
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stall[%0d]: got %s, required %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // HALT ignores inputs; only an asynchronous reset leaves it.
  task automatic test_halt();
    stim_t sv[5];
    obs_t  got, want;
    sv = '{s(0, 1, 0, 0, 0), s(1, 0, 0, 0, 0), s(1, 1, 0, 0, 0),
           s(0, 0, 0, 0, 0), s(1, 1, 0, 1, 0)};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(sv[i]);
      exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 32'd9));
      #1;
      got  = sample(0);
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL halt[%0d]: got %s, required %s", i, fmt(got), fmt(want));
      end
    end
    @(negedge clk);
    #2;
    areset_a = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 32'd0));
    #1;
    got  = sample(0);
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL halt_areset: got %s, required %s", fmt(got), fmt(want));
    end
    @(negedge clk);
    areset_a = 1'b0;
  endtask

  // Three-cycle flush, async reset mid-flush, then counter wrap.
  task automatic test_flush_reset_wrap();
    stim_t sv[10];
    obs_t  ev[10];
    stim_t wv[4];
    obs_t  wx[4];
    obs_t  got, want;
    @(negedge clk);
    drive(s(1, 0, 0, 0, 0));
    areset_b = 1'b1;
    @(negedge clk);
    areset_b = 1'b0;
    sv = '{s(1, 0, 0, 0, 0), s(1, 0, 0, 0, 0), s(1, 0, 0, 0, 0),
           s(1, 1, 0, 1, 0), s(1, 1, 0, 0, 0), s(1, 1, 0, 0, 0),
           s(1, 1, 0, 0, 0), s(1, 1, 0, 1, 0), s(1, 1, 0, 0, 0),
           s(1, 1, 0, 0, 0)};
    ev = '{mk(0, 0, 0, 0, 0, 0, 32'd0), mk(1, 0, 0, 0, 0, 0, 32'd0),
           mk(2, 0, 0, 0, 0, 0, 32'd0), mk(2, 1, 1, 1, 0, 0, 32'd0),
           mk(3, 0, 0, 0, 1, 0, 32'd1), mk(3, 0, 0, 0, 1, 0, 32'd1),
           mk(3, 0, 0, 0, 1, 0, 32'd1), mk(2, 1, 1, 1, 0, 0, 32'd1),
           mk(3, 0, 0, 0, 1, 0, 32'd2), mk(3, 0, 0, 0, 1, 0, 32'd2)};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(sv[i]);
      exp_q.push_back(ev[i]);
      #1;
      got  = sample(1);
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL flush3[%0d]: got %s, required %s", i, fmt(got), fmt(want));
      end
    end
    #1;
    areset_b = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 32'd0));
    #1;
    got  = sample(1);
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL flush_areset: got %s, required %s", fmt(got), fmt(want));
    end
    @(negedge clk);
    drive(s(0, 0, 0, 0, 0));
    areset_b = 1'b0;
    repeat (2) @(negedge clk);
    force dut_b.retired_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_b.retired_count_q;
    wv = '{s(0, 0, 0, 0, 0), s(1, 0, 0, 0, 0), s(1, 1, 0, 0, 0), s(0, 0, 0, 0, 0)};
    wx = '{mk(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF), mk(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF),
           mk(2, 1, 0, 1, 0, 0, 32'hFFFF_FFFF), mk(2, 0, 0, 0, 0, 0, 32'd0)};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(wv[i]);
      exp_q.push_back(wx[i]);
      #1;
      got  = sample(1);
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %s, required %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    areset_a = 1'b1;
    areset_b = 1'b1;
    drive(s(0, 0, 0, 0, 0));
    test_reset();
    test_fetch();
    test_branch();
    test_stall_priority();
    test_halt();
    test_flush_reset_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
